// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer and its datapath:
// state encoding, RV32 base opcode constants, fault codes and the opcode class record.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // legal covers every executable opcode; SYSTEM halts and is flagged separately.
  typedef struct packed {
    logic legal;
    logic system;
    logic load;
    logic store;
    logic branch;
  } opclass_t;

endpackage

// File: rtl/instr_sequencer_opcode_class.sv
// Combinational opcode legality / class decode shared by the sequencer phases.
module opcode_class
  import instr_sequencer_pkg::*;
(
  input  logic [6:0] i_opcode,
  output opclass_t   o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OPC_SYSTEM: o_class.system = 1'b1;
      OPC_LOAD: begin
        o_class.legal = 1'b1;
        o_class.load  = 1'b1;
      end
      OPC_STORE: begin
        o_class.legal = 1'b1;
        o_class.store = 1'b1;
      end
      OPC_BRANCH: begin
        o_class.legal  = 1'b1;
        o_class.branch = 1'b1;
      end
      OPC_OP, OPC_OPIMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: o_class.legal = 1'b1;
      default: o_class = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: Moore phase strobes from state, a memory wait
// watchdog, fault reporting and a retired-instruction counter.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int WORDSIZE    = 64,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  output logic                fetch,
  output logic                decode,
  output logic                execute,
  output logic                mem_req,
  output logic                dm_write_en,
  output logic                rf_write_en,
  output logic                pc_write_en,
  output logic                finished,
  output logic [1:0]          fault,
  output logic [WORDSIZE-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [6:0]          r_opcode_q;
  logic [WAIT_W-1:0]   r_wait;
  logic [WORDSIZE-1:0] r_count;
  logic [1:0]          r_fault;
  logic [1:0]          w_fault_next;
  logic                w_clear;
  logic                w_wait_expired;
  logic [6:0]          w_cls_opcode;
  opclass_t            w_cls;

  // DECODE classifies the live IR field; later phases use the copy latched on DECODE exit.
  assign w_cls_opcode   = (r_state == S_DECODE) ? opcode : r_opcode_q;
  assign w_wait_expired = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
  assign instr_count    = r_count;
  assign fault          = r_fault;

  opcode_class u_opcode_class (
    .i_opcode (w_cls_opcode),
    .o_class  (w_cls)
  );

  always_comb begin
    w_state_next = r_state;
    w_fault_next = r_fault;
    w_clear      = 1'b0;
    fetch        = 1'b0;
    decode       = 1'b0;
    execute      = 1'b0;
    mem_req      = 1'b0;
    dm_write_en  = 1'b0;
    rf_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    finished     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_fault_next = FAULT_NONE;
          w_clear      = 1'b1;
        end
      end
      S_FETCH: begin
        fetch = 1'b1;
        if (mem_ready) begin
          w_state_next = S_DECODE;
        end else if (w_wait_expired) begin
          w_state_next = S_DONE;
          w_fault_next = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        decode = 1'b1;
        if (w_cls.system) begin
          w_state_next = S_DONE;
          w_fault_next = FAULT_NONE;
        end else if (!w_cls.legal) begin
          w_state_next = S_DONE;
          w_fault_next = FAULT_ILLEGAL;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        execute = 1'b1;
        if (w_cls.load || w_cls.store) begin
          w_state_next = S_MEM;
        end else if (w_cls.branch) begin
          w_state_next = S_FETCH;
          pc_write_en  = 1'b1;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req     = 1'b1;
        dm_write_en = w_cls.store;
        if (mem_ready) begin
          // A store retires on its acknowledge; a load still needs its writeback.
          w_state_next = w_cls.store ? S_FETCH : S_WB;
          pc_write_en  = w_cls.store;
        end else if (w_wait_expired) begin
          w_state_next = S_DONE;
          w_fault_next = FAULT_TIMEOUT;
        end
      end
      S_WB: begin
        rf_write_en  = 1'b1;
        pc_write_en  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_DONE: begin
        finished = 1'b1;
        if (start) begin
          w_state_next = S_FETCH;
          w_fault_next = FAULT_NONE;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_opcode_q <= '0;
      r_wait     <= '0;
      r_count    <= '0;
      r_fault    <= FAULT_NONE;
    end else begin
      r_state <= w_state_next;
      r_fault <= w_fault_next;
      if (r_state == S_DECODE) begin
        r_opcode_q <= opcode;
      end
      if (w_state_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_clear) begin
        r_count <= '0;
      end else if (pc_write_en) begin
        r_count <= r_count + WORDSIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model expands each instruction into
// its expected per-cycle strobe pattern, which each scenario task drives and compares.
module tb_instr_sequencer;

  localparam int WS  = 4;
  localparam int TMO = 16;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // {fetch,decode,execute,mem_req,dm_write_en,rf_write_en,pc_write_en,finished,fault[1:0]}
  localparam logic [9:0] E_FETCH = 10'b1000000000;
  localparam logic [9:0] E_DEC   = 10'b0100000000;
  localparam logic [9:0] E_EXEC  = 10'b0010000000;
  localparam logic [9:0] E_MEM   = 10'b0001000000;
  localparam logic [9:0] E_DMW   = 10'b0000100000;
  localparam logic [9:0] E_RF    = 10'b0000010000;
  localparam logic [9:0] E_PC    = 10'b0000001000;
  localparam logic [9:0] E_FIN   = 10'b0000000100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_ready = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          fetch, decode, execute, mem_req, dm_write_en, rf_write_en, pc_write_en, finished;
  logic [1:0]    fault;
  logic [WS-1:0] instr_count;

  always #5 clk = ~clk;

  instr_sequencer #(.WORDSIZE(WS), .MEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .fetch       (fetch),
    .decode      (decode),
    .execute     (execute),
    .mem_req     (mem_req),
    .dm_write_en (dm_write_en),
    .rf_write_en (rf_write_en),
    .pc_write_en (pc_write_en),
    .finished    (finished),
    .fault       (fault),
    .instr_count (instr_count)
  );

  wire [9:0] w_obs = {fetch, decode, execute, mem_req, dm_write_en, rf_write_en,
                      pc_write_en, finished, fault};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0]    q_exp[$];
  logic [WS-1:0] q_cnt[$];
  logic          q_rdy[$];
  logic          q_st[$];
  logic [6:0]    q_op[$];

  logic [WS-1:0] m_count = '0;
  logic [1:0]    m_fault = 2'b00;
  bit            m_done = 1'b0;
  bit            busy_noise = 1'b0;

  logic [6:0] legal_ops [9] = '{LOAD, STORE, OP, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC};

  function automatic bit is_legal(logic [6:0] op);
    return op inside {LOAD, STORE, OP, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC};
  endfunction

  function automatic logic noise();
    if (!busy_noise) return 1'b0;
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push_cyc(logic [9:0] e, logic rdy, logic st, logic [6:0] op);
    q_exp.push_back(e);
    q_cnt.push_back(m_count);
    q_rdy.push_back(rdy);
    q_st.push_back(st);
    q_op.push_back(op);
  endfunction

  function automatic void plan_start();
    push_cyc(m_done ? (E_FIN | {8'd0, m_fault}) : 10'd0, rnd_bit(), 1'b1, 7'($urandom));
    m_count = '0;
    m_fault = 2'b00;
    m_done  = 1'b0;
  endfunction

  function automatic void plan_done(int n);
    for (int i = 0; i < n; i++) push_cyc(E_FIN | {8'd0, m_fault}, rnd_bit(), 1'b0, 7'($urandom));
  endfunction

  // fd/md: cycles of mem_ready=0 before the acknowledge in FETCH / MEM.
  function automatic void plan_instr(logic [6:0] op, int fd, int md);
    bit st;
    for (int i = 0; i < ((fd >= TMO) ? TMO : fd); i++) push_cyc(E_FETCH, 1'b0, noise(), 7'($urandom));
    if (fd >= TMO) begin
      m_fault = 2'b10;
      m_done  = 1'b1;
      return;
    end
    push_cyc(E_FETCH, 1'b1, noise(), 7'($urandom));
    push_cyc(E_DEC, rnd_bit(), noise(), op);
    if (op == SYSTEM || !is_legal(op)) begin
      m_fault = (op == SYSTEM) ? 2'b00 : 2'b01;
      m_done  = 1'b1;
      return;
    end
    if (op == BRANCH) begin
      push_cyc(E_EXEC | E_PC, rnd_bit(), noise(), 7'($urandom));
      m_count++;
      return;
    end
    push_cyc(E_EXEC, rnd_bit(), noise(), 7'($urandom));
    if (op == LOAD || op == STORE) begin
      st = (op == STORE);
      for (int i = 0; i < ((md >= TMO) ? TMO : md); i++)
        push_cyc(E_MEM | (st ? E_DMW : 10'd0), 1'b0, noise(), 7'($urandom));
      if (md >= TMO) begin
        m_fault = 2'b10;
        m_done  = 1'b1;
        return;
      end
      push_cyc(E_MEM | (st ? (E_DMW | E_PC) : 10'd0), 1'b1, noise(), 7'($urandom));
      if (st) begin
        m_count++;
        return;
      end
    end
    push_cyc(E_RF | E_PC, rnd_bit(), noise(), 7'($urandom));
    m_count++;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; mem_ready = 1'b1; opcode = OPIMM;
    #2;
    total++; if (w_obs !== 10'd0) begin bad++; $display("FAIL reset_outs got=%b want=%b", w_obs, 10'd0); end
    total++; if (instr_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", instr_count); end
    @(posedge clk); #1;
    total++; if (w_obs !== 10'd0) begin bad++; $display("FAIL reset_held got=%b want=%b", w_obs, 10'd0); end
    #2 rst_n = 1'b1;
    #1;
    total++; if (w_obs !== 10'd0) begin bad++; $display("FAIL release_no_edge got=%b want=%b", w_obs, 10'd0); end
    @(posedge clk); #1;
    total++; if (w_obs !== E_FETCH) begin bad++; $display("FAIL release_first_edge got=%b want=%b", w_obs, E_FETCH); end
    start = 1'b0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (w_obs !== 10'd0) begin bad++; $display("FAIL async_reset got=%b want=%b", w_obs, 10'd0); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (w_obs !== 10'd0) begin bad++; $display("FAIL idle_no_start got=%b want=%b", w_obs, 10'd0); end
    m_count = '0; m_fault = 2'b00; m_done = 1'b0;
    $display("test_reset: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_op_imm();
    logic [9:0] e; logic [WS-1:0] c;
    plan_start();
    plan_instr(OPIMM, 0, 0);
    plan_instr(SYSTEM, 0, 0);
    plan_done(2);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL opimm_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL opimm_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    total++; if (instr_count !== 4'd1) begin bad++; $display("FAIL opimm_final_count got=%0d want=1", instr_count); end
    $display("test_op_imm: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_store_delay();
    logic [9:0] e; logic [WS-1:0] c;
    plan_start();
    plan_instr(STORE, 0, 3);
    plan_instr(SYSTEM, 1, 0);
    plan_done(2);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL store_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL store_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    $display("test_store_delay: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_load_branch_system();
    logic [9:0] e; logic [WS-1:0] c;
    plan_start();
    plan_instr(LOAD, 0, 0);
    plan_instr(BRANCH, 0, 0);
    plan_instr(SYSTEM, 0, 0);
    plan_done(2);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL lbs_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL lbs_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    total++; if (instr_count !== 4'd2 || fault !== 2'b00 || finished !== 1'b1) begin
      bad++; $display("FAIL lbs_final got=cnt %0d fault %b fin %b want=cnt 2 fault 00 fin 1", instr_count, fault, finished);
    end
    $display("test_load_branch_system: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_illegal_restart();
    logic [9:0] e; logic [WS-1:0] c;
    plan_start();
    plan_instr(OP, 0, 0);
    plan_instr(7'b0000000, 0, 0);
    plan_done(2);
    plan_start();
    plan_instr(OPIMM, 2, 0);
    plan_instr(SYSTEM, 0, 0);
    plan_done(1);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL illegal_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL illegal_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    $display("test_illegal_restart: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_timeout();
    logic [9:0] e; logic [WS-1:0] c;
    plan_start();
    plan_instr(OPIMM, TMO - 1, 0);
    plan_instr(OP, TMO + 4, 0);
    plan_done(2);
    plan_start();
    plan_instr(LOAD, 0, TMO);
    plan_done(2);
    plan_start();
    plan_instr(STORE, 1, TMO - 1);
    plan_instr(SYSTEM, 0, 0);
    plan_done(1);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL timeout_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL timeout_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    $display("test_timeout: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_wrap();
    logic [9:0] e; logic [WS-1:0] c;
    busy_noise = 1'b1;
    plan_start();
    for (int i = 0; i < 18; i++)
      plan_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2));
    plan_instr(SYSTEM, 0, 0);
    plan_done(1);
    busy_noise = 1'b0;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL wrap_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    total++; if (instr_count !== 4'd2) begin bad++; $display("FAIL wrap_final got=%0d want=2", instr_count); end
    $display("test_wrap: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    logic [9:0] e; logic [WS-1:0] c; logic [6:0] op; int r;
    busy_noise = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (m_done) plan_start();
      r = $urandom_range(0, 19);
      if (r == 0) op = SYSTEM;
      else if (r == 1) begin
        op = 7'($urandom);
        while (is_legal(op) || op == SYSTEM) op = 7'($urandom);
      end else op = legal_ops[$urandom_range(0, 8)];
      plan_instr(op, ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3));
    end
    if (!m_done) plan_instr(SYSTEM, 0, 0);
    busy_noise = 1'b0;
    plan_done(2);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL random_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      total++; if (instr_count !== c) begin bad++; $display("FAIL random_count cyc=%0d got=%0d want=%0d", cyc, instr_count, c); end
      @(posedge clk); #1; cyc++;
    end
    $display("test_random: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid_mem();
    logic [9:0] e; logic [WS-1:0] c;
    plan_start();
    plan_instr(STORE, 0, TMO + 8);
    for (int k = 0; k < 6; k++) begin
      e = q_exp.pop_front(); c = q_cnt.pop_front();
      mem_ready = q_rdy.pop_front(); start = q_st.pop_front(); opcode = q_op.pop_front();
      @(negedge clk);
      total++; if (w_obs !== e) begin bad++; $display("FAIL midmem_outs cyc=%0d got=%b want=%b", cyc, w_obs, e); end
      @(posedge clk); #1; cyc++;
    end
    q_exp.delete(); q_cnt.delete(); q_rdy.delete(); q_st.delete(); q_op.delete();
    mem_ready = 1'b0; start = 1'b0;
    #2;
    total++; if ({mem_req, dm_write_en} !== 2'b11) begin bad++; $display("FAIL midmem_active got=%b want=11", {mem_req, dm_write_en}); end
    rst_n = 1'b0;
    #1;
    total++; if (w_obs !== 10'd0) begin bad++; $display("FAIL midmem_async_drop got=%b want=%b", w_obs, 10'd0); end
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (w_obs !== 10'd0 || instr_count !== '0) begin
        bad++; $display("FAIL midmem_after_release k=%0d got=%b cnt %0d want=%b cnt 0", k, w_obs, instr_count, 10'd0);
      end
      @(posedge clk); #1;
    end
    m_count = '0; m_fault = 2'b00; m_done = 1'b0;
    $display("test_reset_mid_mem: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_op_imm();
    test_store_delay();
    test_load_branch_system();
    test_illegal_restart();
    test_timeout();
    test_wrap();
    test_random();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
